// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: opcodes, default latencies, payload types.
package md_unit_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // Operation captured at launch
   typedef struct packed {
      md_op_e          op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } md_req_t;

   // Result of an arithmetic op; wr=0 means leave HI/LO untouched
   typedef struct packed {
      logic            wr;
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
   } md_res_t;

   // True for the ops that occupy the unit for several cycles
   function automatic logic is_arith_op(md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the divide ops (longer latency)
   function automatic logic is_div_op(md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage link between the operand/issue side and the multiply/divide unit.
interface md_unit_if;
   import md_unit_pkg::*;

   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [2:0]      md_op;
   logic            start;
   logic            busy;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic            stall_req;

   modport master (
      output a, b, md_op, start,
      input  busy, hi, lo, stall_req
   );

   modport slave (
      input  a, b, md_op, start,
      output busy, hi, lo, stall_req
   );

endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Result is combinational from the latched operands; the counter alone sets
// the (data-independent) latency.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic      clk,
   input  logic      rst_n,
   md_unit_if.slave  bus
);

   localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   md_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   md_req_t         req_q, req_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;

   md_op_e  op_in;
   logic    launch;
   logic    done;
   md_res_t res;

   // Signed/unsigned multiply and divide on the latched operands
   function automatic md_res_t md_calc(md_req_t r);
      md_res_t                 o;
      logic signed [2*XLEN-1:0] sprod;
      logic        [2*XLEN-1:0] uprod;
      logic signed [XLEN-1:0]   sa;
      logic signed [XLEN-1:0]   sdiv;
      logic signed [XLEN-1:0]   sq;
      logic signed [XLEN-1:0]   sr;
      logic        [XLEN-1:0]   udiv;
      o     = '0;
      sprod = $signed({{XLEN{r.a[XLEN-1]}}, r.a}) * $signed({{XLEN{r.b[XLEN-1]}}, r.b});
      uprod = {{XLEN{1'b0}}, r.a} * {{XLEN{1'b0}}, r.b};
      // Divisor forced non-zero so the divider never sees 0; wr gates the result
      sa    = $signed(r.a);
      sdiv  = $signed(r.b);
      udiv  = r.b;
      if (r.b == '0) begin
         sdiv = XLEN'(1);
         udiv = XLEN'(1);
      end
      sq = sa / sdiv;
      sr = sa % sdiv;
      case (r.op)
         MD_MULT: begin
            o.wr = 1'b1;
            {o.hi, o.lo} = sprod;
         end
         MD_MULTU: begin
            o.wr = 1'b1;
            {o.hi, o.lo} = uprod;
         end
         MD_DIV: begin
            o.wr = (r.b != '0);
            // Most-negative / -1 overflows: quotient wraps to the dividend
            if ((r.a == {1'b1, {(XLEN-1){1'b0}}}) && (r.b == '1)) begin
               o.lo = r.a;
               o.hi = '0;
            end else begin
               o.lo = sq;
               o.hi = sr;
            end
         end
         MD_DIVU: begin
            o.wr = (r.b != '0);
            o.lo = r.a / udiv;
            o.hi = r.a % udiv;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

   assign op_in  = md_op_e'(bus.md_op);
   assign launch = (state_q == ST_IDLE) && bus.start && is_arith_op(op_in);
   assign done   = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));
   assign res    = md_calc(req_q);

   // State, counter, operand and HI/LO registers; reset wins over everything
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Next-state: launch into RUN, fall back to IDLE on the last count
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (launch) state_d = ST_RUN;
         ST_RUN:  if (done)   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, countdown, HI/LO writes
   always_comb begin
      cnt_d = cnt_q;
      req_d = req_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               req_d.op = op_in;
               req_d.a  = bus.a;
               req_d.b  = bus.b;
               cnt_d    = is_div_op(op_in) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (op_in == MD_MTHI) begin
               hi_d = bus.a;
            end else if (op_in == MD_MTLO) begin
               lo_d = bus.a;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (done && res.wr) begin
               hi_d = res.hi;
               lo_d = res.lo;
            end
         end
         default: ;
      endcase
   end

   assign bus.busy      = (state_q == ST_RUN);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.stall_req = bus.start | bus.busy;

endmodule
